// File: rtl/axis_pkg.sv
// Shared types for the credit-based stream sender.
package axis_pkg;

    typedef enum logic {
        CS_DOWN,
        CS_RUN
    } credit_state_e;

    localparam int DEFAULT_CREDITS = 4;

endpackage

// File: rtl/axis_if.sv
// AXI Stream beat interface (valid/ready/data) with source and sink views.
interface axis_if #(
    parameter int TDATA_WIDTH = 8
) ();

    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;

    modport m (output tvalid, output tdata, input  tready);
    modport s (input  tvalid, input  tdata, output tready);

endinterface

// File: rtl/axis_credit_sender.sv
// Credit-based stream transmitter: AXI Stream in, valid-only link out,
// sending only while the remote FIFO has advertised free slots.
module axis_credit_sender
    import axis_pkg::*;
#(
    parameter  int CREDITS     = DEFAULT_CREDITS,
    parameter  int TDATA_WIDTH = 8,   // must match the connected axis_if
    localparam int CNT_W       = $clog2(CREDITS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    axis_if.s                      axis_sif,
    output logic                   link_valid,
    output logic [TDATA_WIDTH-1:0] link_data,
    input  logic                   credit_return,
    input  logic                   link_up,
    input  logic                   invalidate,
    output logic [CNT_W-1:0]       credits,
    output logic                   credit_ovf
);

    localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

    if (CREDITS < 1) begin : g_bad_credits
        $error("axis_credit_sender: CREDITS must be >= 1");
    end
    if (TDATA_WIDTH <= 0) begin : g_bad_width
        $error("axis_credit_sender: TDATA_WIDTH must be > 0");
    end

    credit_state_e          state_q, state_d;
    logic [CNT_W-1:0]       credits_q, credits_d;
    logic                   tready_q, tready_d;
    logic                   link_valid_q, link_valid_d;
    logic [TDATA_WIDTH-1:0] link_data_q, link_data_d;
    logic                   credit_ovf_q, credit_ovf_d;
    logic                   send, ret;

    always_comb begin
        state_d      = state_q;
        credits_d    = credits_q;
        link_valid_d = 1'b0;
        link_data_d  = link_data_q;
        credit_ovf_d = credit_ovf_q;

        send = axis_sif.tvalid && tready_q;
        ret  = credit_return && (state_q == CS_RUN);

        case (state_q)
            CS_DOWN: if (link_up)  state_d = CS_RUN;
            CS_RUN:  if (!link_up) state_d = CS_DOWN;
            default: state_d = CS_DOWN;
        endcase

        if (send && !ret) begin
            credits_d = credits_q - CNT_W'(1);
        end else if (ret && !send) begin
            // A return with every slot already free is a protocol error upstream.
            if (credits_q == CRED_MAX) credit_ovf_d = 1'b1;
            else                       credits_d    = credits_q + CNT_W'(1);
        end

        if (state_d == CS_DOWN || invalidate) begin
            credits_d = CRED_MAX;
        end else if (send) begin
            link_valid_d = 1'b1;
            link_data_d  = axis_sif.tdata;
        end

        // Registered ready: looks ahead at next state and count, never at inputs directly.
        tready_d = (state_d == CS_RUN) && (credits_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CS_DOWN;
            credits_q    <= CRED_MAX;
            tready_q     <= 1'b0;
            link_valid_q <= 1'b0;
            link_data_q  <= '0;
            credit_ovf_q <= 1'b0;
        end else begin
            assert (!(send && credits_q == '0))
                else $error("axis_credit_sender: send with zero credits");
            state_q      <= state_d;
            credits_q    <= credits_d;
            tready_q     <= tready_d;
            link_valid_q <= link_valid_d;
            link_data_q  <= link_data_d;
            credit_ovf_q <= credit_ovf_d;
        end
    end

    assign axis_sif.tready = tready_q;
    assign link_valid      = link_valid_q;
    assign link_data       = link_data_q;
    assign credits         = credits_q;
    assign credit_ovf      = credit_ovf_q;

endmodule

// File: tb/tb_axis_credit_sender.sv
// Bench for axis_credit_sender: directed vector table, corner sequences,
// then random traffic against a cycle-level behavioural model.
module tb_axis_credit_sender;

    localparam int CREDITS = 4;
    localparam int W       = 8;
    localparam int CNT_W   = $clog2(CREDITS + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             link_valid;
    logic [W-1:0]     link_data;
    logic             credit_return;
    logic             link_up;
    logic             invalidate;
    logic [CNT_W-1:0] credits;
    logic             credit_ovf;

    int checks   = 0;
    int failures = 0;

    axis_if #(.TDATA_WIDTH(W)) axis ();

    axis_credit_sender #(.CREDITS(CREDITS), .TDATA_WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .axis_sif      (axis),
        .link_valid    (link_valid),
        .link_data     (link_data),
        .credit_return (credit_return),
        .link_up       (link_up),
        .invalidate    (invalidate),
        .credits       (credits),
        .credit_ovf    (credit_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, up, tv;
        logic [7:0] d;
        logic       ret, inv;
        logic       e_tr, e_lv;
        logic [7:0] e_ld;
        int         e_cr;
        logic       e_ovf;
    } vec_t;

    // Behavioural model: credits as a plain integer, state as "link is up".
    int         m_cred;
    bit         m_up, m_ovf, m_lv, m_tr;
    logic [7:0] m_ld;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, up, tv, input logic [7:0] d, input logic ret, inv);
        rst = r; link_up = up; axis.tvalid = tv; axis.tdata = d;
        credit_return = ret; invalidate = inv;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic tr, lv, input logic [7:0] ld,
                              input int cr, input logic ovf);
        chk({nm, ".tready"}, int'(axis.tready), int'(tr));
        chk({nm, ".link_valid"}, int'(link_valid), int'(lv));
        if (lv) chk({nm, ".link_data"}, int'(link_data), int'(ld));
        chk({nm, ".credits"}, int'(credits), cr);
        chk({nm, ".credit_ovf"}, int'(credit_ovf), int'(ovf));
    endtask

    task automatic model_step(input logic r, up, tv, input logic [7:0] d, input logic ret, inv);
        bit hs, rt;
        int nc;
        if (r) begin
            m_up = 0; m_cred = CREDITS; m_ovf = 0; m_lv = 0; m_ld = '0; m_tr = 0;
            return;
        end
        hs = tv && m_tr;
        rt = ret && m_up;
        if (rt && !hs && m_cred == CREDITS) m_ovf = 1;
        nc = m_cred - int'(hs) + int'(rt);
        if (nc > CREDITS) nc = CREDITS;
        m_up = up;
        if (!up || inv) begin
            m_cred = CREDITS; m_lv = 0;
        end else begin
            m_cred = nc; m_lv = hs;
            if (hs) m_ld = d;
        end
        m_tr = m_up && (m_cred != 0);
    endtask

    vec_t vt[$];

    function automatic vec_t mk(input logic r, up, tv, input logic [7:0] d, input logic ret, inv,
                                input logic tr, lv, input logic [7:0] ld, input int cr,
                                input logic ovf);
        vec_t v;
        v.rst = r; v.up = up; v.tv = tv; v.d = d; v.ret = ret; v.inv = inv;
        v.e_tr = tr; v.e_lv = lv; v.e_ld = ld; v.e_cr = cr; v.e_ovf = ovf;
        return v;
    endfunction

    initial begin
        //             rst up tv d      ret inv | tr lv ld     cr ovf
        vt.push_back(mk(1, 0, 1, 8'h10, 0, 0,    0, 0, 8'h00, 4, 0)); // reset
        vt.push_back(mk(0, 0, 1, 8'h10, 0, 0,    0, 0, 8'h00, 4, 0)); // down, tvalid high
        vt.push_back(mk(0, 0, 1, 8'h10, 0, 0,    0, 0, 8'h00, 4, 0));
        vt.push_back(mk(0, 1, 1, 8'h10, 0, 0,    1, 0, 8'h00, 4, 0)); // link comes up
        vt.push_back(mk(0, 1, 1, 8'h10, 0, 0,    1, 1, 8'h10, 3, 0)); // burst of CREDITS
        vt.push_back(mk(0, 1, 1, 8'h11, 0, 0,    1, 1, 8'h11, 2, 0));
        vt.push_back(mk(0, 1, 1, 8'h12, 0, 0,    1, 1, 8'h12, 1, 0));
        vt.push_back(mk(0, 1, 1, 8'h13, 0, 0,    0, 1, 8'h13, 0, 0));
        vt.push_back(mk(0, 1, 1, 8'h14, 0, 0,    0, 0, 8'h13, 0, 0)); // stalled
        vt.push_back(mk(0, 1, 1, 8'h14, 0, 0,    0, 0, 8'h13, 0, 0));
        vt.push_back(mk(0, 1, 1, 8'h14, 1, 0,    1, 0, 8'h13, 1, 0)); // return at 0
        vt.push_back(mk(0, 1, 1, 8'h14, 0, 0,    0, 1, 8'h14, 0, 0));
        vt.push_back(mk(0, 1, 0, 8'h00, 1, 0,    1, 0, 8'h14, 1, 0));
        vt.push_back(mk(0, 1, 0, 8'h00, 1, 0,    1, 0, 8'h14, 2, 0));
        vt.push_back(mk(0, 1, 1, 8'h15, 1, 0,    1, 1, 8'h15, 2, 0)); // send+ret
        vt.push_back(mk(0, 1, 0, 8'h00, 1, 0,    1, 0, 8'h15, 3, 0));
        vt.push_back(mk(0, 1, 0, 8'h00, 1, 0,    1, 0, 8'h15, 4, 0));
        vt.push_back(mk(0, 1, 0, 8'h00, 1, 0,    1, 0, 8'h15, 4, 1)); // overflow
        vt.push_back(mk(0, 1, 0, 8'h00, 0, 1,    1, 0, 8'h15, 4, 1)); // sticky over inv
        vt.push_back(mk(0, 1, 0, 8'h00, 0, 0,    1, 0, 8'h15, 4, 1));

        rst = 1'b1; link_up = 1'b0; axis.tvalid = 1'b0; axis.tdata = '0;
        credit_return = 1'b0; invalidate = 1'b0;
        #1;

        foreach (vt[i]) begin
            cyc(vt[i].rst, vt[i].up, vt[i].tv, vt[i].d, vt[i].ret, vt[i].inv);
            expect_out($sformatf("vec%0d", i), vt[i].e_tr, vt[i].e_lv, vt[i].e_ld,
                       vt[i].e_cr, vt[i].e_ovf);
        end

        // Mid-burst invalidate drops the concurrent beat.
        cyc(0, 1, 1, 8'h20, 0, 0); expect_out("inv_a", 1, 1, 8'h20, 3, 1);
        cyc(0, 1, 1, 8'h21, 0, 1); expect_out("inv_b", 1, 0, 8'h20, 4, 1);
        chk("inv_b.hold_data", int'(link_data), 'h20);
        cyc(0, 1, 1, 8'h22, 0, 0); expect_out("inv_c", 1, 1, 8'h22, 3, 1);
        // link_up drop mid-burst.
        cyc(0, 0, 1, 8'h23, 0, 0); expect_out("down_a", 0, 0, 8'h22, 4, 1);
        cyc(0, 0, 1, 8'h24, 1, 0); expect_out("down_b", 0, 0, 8'h22, 4, 1);
        cyc(0, 1, 1, 8'h24, 0, 0); expect_out("down_c", 1, 0, 8'h22, 4, 1);
        cyc(0, 1, 1, 8'h25, 0, 0); expect_out("down_d", 1, 1, 8'h25, 3, 1);
        // Reset mid-stream.
        cyc(1, 1, 1, 8'h26, 0, 0); expect_out("rst_mid", 0, 0, 8'h00, 4, 0);
        chk("rst_mid.data", int'(link_data), 0);

        // Random traffic against the model.
        model_step(1, 0, 0, 8'h00, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic r, up, tv, ret, inv;
            logic [7:0] d;
            r   = (n == 0) || ($urandom_range(0, 299) == 0);
            up  = ($urandom_range(0, 24) != 0);
            tv  = ($urandom_range(0, 3) != 0);
            ret = ($urandom_range(0, 9) < 4);
            inv = ($urandom_range(0, 39) == 0);
            d   = 8'($urandom);
            model_step(r, up, tv, d, ret, inv);
            cyc(r, up, tv, d, ret, inv);
            expect_out($sformatf("rnd%0d", n), m_tr, m_lv, m_ld, m_cred, m_ovf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
